// File: rtl/hc595_disp_tx.sv
// hc595_disp_tx: double-dabble BCD of disp_data scanned over 8 digits, each digit frame
// shifted MSB-first into two daisy-chained 74HC595s (segment byte, then digit-select byte).
module hc595_disp_tx #(
   parameter int SCAN_DIV = 50000,
   parameter int SCLK_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] disp_data,
   input  logic [2:0]  flag,
   output logic        sh_cp,
   output logic        st_cp,
   output logic        ds,
   output logic        busy
);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam int DW = $clog2(SCLK_DIV + 1);
   // sh_cp and st_cp are direct state bits so the HC595 clocks never glitch
   typedef enum logic [2:0] {IDLE = 3'b000, LO = 3'b001, HI = 3'b010, LATCH = 3'b100} state_t;
   state_t state_q, state_d;
   logic [SW-1:0] scan_q, scan_d;
   logic [DW-1:0] div_q, div_d;
   logic [2:0]    dig_q, dig_d;
   logic [15:0]   frame_q, frame_d;
   logic [4:0]    bits_q, bits_d;
   logic [19:0]   bin_q, bin_d;
   logic [27:0]   bcd_q, bcd_d, shown_q, shown_d, adj;
   logic [4:0]    conv_q, conv_d;
   logic [31:0]   digits;
   logic [7:0]    seg;
   logic          tick, div_end;

   function automatic logic [7:0] seg_code(input logic [3:0] n);
      case (n)
         4'd0: seg_code = 8'hC0;
         4'd1: seg_code = 8'hF9;
         4'd2: seg_code = 8'hA4;
         4'd3: seg_code = 8'hB0;
         4'd4: seg_code = 8'h99;
         4'd5: seg_code = 8'h92;
         4'd6: seg_code = 8'h82;
         4'd7: seg_code = 8'hF8;
         4'd8: seg_code = 8'h80;
         4'd9: seg_code = 8'h90;
         default: seg_code = 8'hFF;
      endcase
   endfunction

   always_comb begin
      tick = scan_q == SW'(SCAN_DIV - 1);
      scan_d = tick ? '0 : scan_q + 1'b1;
      dig_d = tick ? dig_q + 3'd1 : dig_q;
   end

   // conv_q 21..2 runs the 20 shift/add-3 steps, 1 publishes the finished snapshot
   always_comb begin
      for (int i = 0; i < 7; i++)
         adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
      bin_d = bin_q;
      bcd_d = bcd_q;
      shown_d = shown_q;
      conv_d = conv_q;
      if (tick && dig_d == 3'd7) begin
         bin_d = disp_data;
         bcd_d = '0;
         conv_d = 5'd21;
      end else if (conv_q != 5'd0) begin
         conv_d = conv_q - 5'd1;
         if (conv_q == 5'd1) shown_d = bcd_q;
         else {bcd_d, bin_d} = {adj, bin_q} << 1;
      end
   end

   always_comb begin
      digits = {4'h0, shown_q};
      seg = dig_d == 3'd7 ? seg_code({1'b0, flag}) & 8'h7F
          : (dig_d != 3'd0 && (digits >> (4 * dig_d)) == 32'd0) ? 8'hFF
          : seg_code(digits[4 * dig_d +: 4]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         scan_q  <= '0;
         div_q   <= '0;
         dig_q   <= 3'd7;
         frame_q <= '0;
         bits_q  <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         shown_q <= '0;
         conv_q  <= '0;
      end else begin
         state_q <= state_d;
         scan_q  <= scan_d;
         div_q   <= div_d;
         dig_q   <= dig_d;
         frame_q <= frame_d;
         bits_q  <= bits_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         shown_q <= shown_d;
         conv_q  <= conv_d;
      end
   end

   always_comb begin
      div_end = div_q == DW'(SCLK_DIV - 1);
      state_d = state_q;
      div_d = div_end ? '0 : div_q + 1'b1;
      frame_d = frame_q;
      bits_d = bits_q;
      case (state_q)
         IDLE: begin
            div_d = '0;
            if (tick) begin
               state_d = LO;
               frame_d = {seg, ~(8'd1 << dig_d)};
               bits_d = 5'd16;
            end
         end
         LO: if (div_end) state_d = HI;
         HI: if (div_end) begin
            frame_d = frame_q << 1;
            bits_d = bits_q - 5'd1;
            state_d = bits_q == 5'd1 ? LATCH : LO;
         end
         LATCH: if (div_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sh_cp = state_q[1];
      st_cp = state_q[2];
      busy = state_q != IDLE;
      ds = frame_q[15];
   end
endmodule

// File: tb/tb_hc595_disp_tx.sv
// tb_hc595_disp_tx: captures each shifted frame off the HC595 pins, checks pin timing,
// and compares frames against constant tables and a decimal-arithmetic display model.
module tb_hc595_disp_tx;
   localparam int SCAN = 200;
   localparam int SCLK = 2;
   typedef struct packed {logic [19:0] v; logic [2:0] f; logic [63:0] seg;} vec_t;

   logic clk = 0, reset = 1;
   logic sh_cp, st_cp, ds, busy;
   logic [19:0] disp_data = 0;
   logic [2:0] flag = 0;
   int n_chk = 0, n_pass = 0;
   logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   vec_t vt [6];

   hc595_disp_tx #(.SCAN_DIV(SCAN), .SCLK_DIV(SCLK)) dut (
      .clk(clk), .reset(reset), .disp_data(disp_data), .flag(flag),
      .sh_cp(sh_cp), .st_cp(st_cp), .ds(ds), .busy(busy));

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, want);
   endfunction

   // Expected frame for digit d showing value v with parameter index f.
   function automatic logic [15:0] model_frame(input int d, input int v, input int f);
      int p;
      logic [7:0] s;
      p = 1;
      for (int k = 0; k < d; k++) p *= 10;
      if (d == 7) s = seg_lut[f] & 8'h7F;
      else if (d > 0 && v < p) s = 8'hFF;
      else s = seg_lut[(v / p) % 10];
      return {s, ~(8'd1 << d)};
   endfunction

   logic p_sh = 0, p_st = 0, p_ds = 0, p_busy = 0;
   logic [15:0] shreg = 0, last_frame = 0;
   int rises = 0, st_w = 0, busy_w = 0, stab = 0, fc = 0;
   int m_dig = 0, m_shown = 0, m_pend = 0;
   logic [15:0] exp_q [$];

   initial forever begin
      @(negedge clk);
      if (reset) begin
         p_sh = 0; p_st = 0; p_ds = 0; p_busy = 0;
         rises = 0; st_w = 0; busy_w = 0; stab = 0; shreg = 0;
         m_dig = 0; m_shown = 0; m_pend = 0;
         exp_q.delete();
      end else begin
         stab = (ds == p_ds) ? stab + 1 : 1;
         if (sh_cp || st_cp) chk("sh_st_excl", {31'd0, sh_cp & st_cp}, 0);
         if (sh_cp && !p_sh) begin
            chk("ds_setup", {31'd0, stab >= SCLK + 1}, 1);
            shreg = {shreg[14:0], ds};
            rises++;
         end
         if (sh_cp && p_sh) chk("ds_hold", {31'd0, ds}, {31'd0, p_ds});
         if (busy && !p_busy) begin
            if (m_dig == 0) m_shown = m_pend;
            if (m_dig == 7) m_pend = int'(disp_data);
            exp_q.push_back(model_frame(m_dig, m_shown, int'(flag)));
            m_dig = (m_dig + 1) % 8;
         end
         if (st_cp && !p_st) begin
            chk("rises_per_latch", rises, 16);
            rises = 0;
            last_frame = shreg;
            fc++;
            if (exp_q.size() > 0) chk("model_frame", {16'd0, shreg}, {16'd0, exp_q.pop_front()});
            else chk("model_frame_missing", {16'd0, shreg}, 32'hFFFF_FFFF);
         end
         if (st_cp) st_w++;
         if (!st_cp && p_st) begin chk("st_width", st_w, SCLK); st_w = 0; end
         if (busy) busy_w++;
         if (!busy && p_busy) begin chk("busy_len", busy_w, 33 * SCLK); busy_w = 0; end
         p_sh = sh_cp; p_st = st_cp; p_ds = ds; p_busy = busy;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic get_frame(output logic [15:0] f);
      int start, t;
      start = fc;
      t = 0;
      while (fc == start && t < 2 * SCAN) begin cyc(); t++; end
      if (fc == start) chk("frame_timeout", 0, 1);
      f = last_frame;
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      while (busy && n < 4 * SCAN) begin cyc(); n++; end
      n = 0;
      while (!busy && n < 4 * SCAN) begin cyc(); n++; end
      if (!busy) chk("busy_timeout", 0, 1);
   endtask

   task automatic seek7();
      logic [15:0] f;
      int k;
      f = 0;
      k = 0;
      while (f[7:0] != 8'h7F && k < 10) begin get_frame(f); k++; end
      if (f[7:0] != 8'h7F) chk("seek_digit7", {16'd0, f}, 32'h7F);
   endtask

   initial begin
      logic [15:0] f;
      int n, lim;
      vt[0] = '{20'd0,       3'd0, 64'h40FF_FFFF_FFFF_FFC0};
      vt[1] = '{20'd12345,   3'd2, 64'h24FF_FFF9_A4B0_9992};
      vt[2] = '{20'd1048575, 3'd5, 64'h12F9_C099_8092_F892};
      vt[3] = '{20'd1000000, 3'd7, 64'h78F9_C0C0_C0C0_C0C0};
      vt[4] = '{20'd9,       3'd1, 64'h79FF_FFFF_FFFF_FF90};
      vt[5] = '{20'd100,     3'd3, 64'h30FF_FFFF_FFF9_C0C0};

      repeat (3) cyc();
      chk("rst_sh_cp", {31'd0, sh_cp}, 0);
      chk("rst_st_cp", {31'd0, st_cp}, 0);
      chk("rst_ds", {31'd0, ds}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      reset = 0;
      wait_busy(n);
      chk("first_tick_latency", n, SCAN);
      get_frame(f);
      chk("first_frame_dig0", {16'd0, f}, 32'hC0FE);
      for (int d = 1; d < 8; d++) get_frame(f);
      chk("first_pass_dig7", {16'd0, f}, 32'h407F);

      for (int i = 0; i < 6; i++) begin
         get_frame(f);
         disp_data = vt[i].v;
         flag = vt[i].f;
         seek7();
         for (int d = 0; d < 8; d++) begin
            get_frame(f);
            chk($sformatf("vec%0d_dig%0d", i, d), {16'd0, f}, {16'd0, vt[i].seg[8*d +: 8], ~(8'd1 << d)});
         end
      end

      get_frame(f);
      disp_data = 20'd111;
      flag = 3'd4;
      seek7();
      for (int d = 0; d < 4; d++) begin
         get_frame(f);
         chk($sformatf("p111_dig%0d", d), {16'd0, f}, {16'd0, d < 3 ? 8'hF9 : 8'hFF, ~(8'd1 << d)});
      end
      disp_data = 20'd222;
      for (int d = 4; d < 8; d++) begin
         get_frame(f);
         chk($sformatf("p111_tail_dig%0d", d), {16'd0, f}, {16'd0, d < 7 ? 8'hFF : 8'h19, ~(8'd1 << d)});
      end
      for (int d = 0; d < 3; d++) begin
         get_frame(f);
         chk($sformatf("p222_dig%0d", d), {16'd0, f}, {16'd0, 8'hA4, ~(8'd1 << d)});
      end

      for (int r = 0; r < 6; r++) begin
         get_frame(f);
         lim = 10 ** $urandom_range(1, 7);
         disp_data = 20'($urandom_range(0, lim > 1048576 ? 1048575 : lim - 1));
         flag = 3'($urandom_range(0, 7));
         for (int k = 0; k < 9 + r % 3; k++) get_frame(f);
      end

      wait_busy(n);
      n = 0;
      while (rises < 8 && n < 100) begin cyc(); n++; end
      chk("reach_bit9", rises, 8);
      repeat (2) cyc();
      reset = 1;
      cyc();
      reset = 0;
      chk("midrst_sh_cp", {31'd0, sh_cp}, 0);
      chk("midrst_st_cp", {31'd0, st_cp}, 0);
      chk("midrst_ds", {31'd0, ds}, 0);
      chk("midrst_busy", {31'd0, busy}, 0);
      wait_busy(n);
      chk("midrst_latency", n, SCAN);
      get_frame(f);
      chk("midrst_dig0", {16'd0, f}, 32'hC0FE);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
